// File: rtl/longop_scoreboard_pkg.sv
// Shared definitions for the long-latency op scoreboard: opcode values,
// per-entry lifecycle encoding and the exception codes written to $rstatus.
package longop_scoreboard_pkg;

   localparam logic MULT_OP = 1'b0;
   localparam logic DIV_OP  = 1'b1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUED = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [2:0] RSTATUS_MULT = 3'd4;
   localparam logic [2:0] RSTATUS_DIV  = 3'd5;

   // Everything an entry needs except the datapath-width result, which
   // depends on XLEN and is therefore stored alongside in its own array.
   typedef struct packed {
      logic [4:0] rd;
      logic       op;
      logic [1:0] state;
      logic       exc;
   } entry_meta_t;

   // Exception code reported for a faulting op of the given kind.
   function automatic logic [2:0] exc_code(input logic op);
      return (op == DIV_OP) ? RSTATUS_DIV : RSTATUS_MULT;
   endfunction

endpackage

// File: rtl/longop_fifo.sv
// In-order circular buffer of in-flight long ops. Entries are allocated at
// the tail, completed in issue order through a separate completion pointer,
// and retired from the head once their result has been written back.
module longop_fifo
   import longop_scoreboard_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [4:0]                   push_rd,
   input  logic                         push_op,
   input  logic                         complete,
   input  logic [XLEN-1:0]              complete_result,
   input  logic                         complete_exc,
   input  logic                         pop,
   output logic                         head_done,
   output logic [4:0]                   head_rd,
   output logic                         head_op,
   output logic [XLEN-1:0]              head_result,
   output logic                         head_exc,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         any_issued
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   entry_meta_t       meta_q   [DEPTH];
   logic [XLEN-1:0]   result_q [DEPTH];
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [PTR_W-1:0]  comp_q;
   logic [CNT_W-1:0]  occ_q;
   logic [CNT_W-1:0]  issued_q;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // Head, tail and completion pointers plus live / still-issued counts.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q   <= '0;
         tail_q   <= '0;
         comp_q   <= '0;
         occ_q    <= '0;
         issued_q <= '0;
      end else begin
         if (push) begin
            tail_q <= wrap_inc(tail_q);
         end
         if (pop) begin
            head_q <= wrap_inc(head_q);
         end
         if (complete) begin
            comp_q <= wrap_inc(comp_q);
         end
         occ_q    <= occ_q + CNT_W'(push) - CNT_W'(pop);
         issued_q <= issued_q + CNT_W'(push) - CNT_W'(complete);
      end
   end

   // Entry contents; push, complete and pop always touch distinct slots.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            meta_q[i]   <= '{rd: 5'd0, op: MULT_OP, state: ST_IDLE, exc: 1'b0};
            result_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (push && tail_q == PTR_W'(i)) begin
               meta_q[i] <= '{rd: push_rd, op: push_op, state: ST_ISSUED, exc: 1'b0};
            end
            if (complete && comp_q == PTR_W'(i)) begin
               meta_q[i].state <= ST_DONE;
               meta_q[i].exc   <= complete_exc;
               result_q[i]     <= complete_result;
            end
            if (pop && head_q == PTR_W'(i)) begin
               meta_q[i].state <= ST_IDLE;
            end
         end
      end
   end

   assign head_done   = (meta_q[head_q].state == ST_DONE);
   assign head_rd     = meta_q[head_q].rd;
   assign head_op     = meta_q[head_q].op;
   assign head_exc    = meta_q[head_q].exc;
   assign head_result = result_q[head_q];
   assign occupancy   = occ_q;
   assign any_issued  = (issued_q != '0);

endmodule

// File: rtl/longop_scoreboard.sv
// Tracks outstanding mult/div ops, raises decode dependency stalls, and
// merges completed long-op results onto the single regfile write port,
// giving MW priority but forcing a hold when the head result starves.
module longop_scoreboard
   import longop_scoreboard_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4,
   parameter int RSTATUS    = 30
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         issue_valid,
   input  logic                         issue_op,
   input  logic [4:0]                   issue_rd,
   output logic                         issue_ready,
   input  logic                         fu_done,
   input  logic [XLEN-1:0]              fu_result,
   input  logic                         fu_exception,
   input  logic [4:0]                   src_a,
   input  logic [4:0]                   src_b,
   input  logic [4:0]                   dst,
   input  logic                         dst_valid,
   output logic                         dep_stall,
   input  logic                         mw_we,
   input  logic [4:0]                   mw_rd,
   input  logic [XLEN-1:0]              mw_data,
   output logic                         mw_hold,
   output logic                         wr_en,
   output logic [4:0]                   wr_reg,
   output logic [XLEN-1:0]              wr_data,
   output logic [31:0]                  pending_mask,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         protocol_err
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_MAX + 1);

   logic              head_done;
   logic [4:0]        head_rd;
   logic              head_op;
   logic [XLEN-1:0]   head_result;
   logic              head_exc;
   logic              any_issued;
   logic              push;
   logic              complete;
   logic              pop;
   logic [31:0]       pending_q;
   logic [31:0]       pending_d;
   logic [STV_W-1:0]  starve_q;
   logic [STV_W-1:0]  starve_d;
   logic              hold_q;
   logic              hold_d;
   logic              perr_q;

   assign issue_ready = (occupancy < CNT_W'(DEPTH));
   assign push        = issue_valid & issue_ready;
   assign complete    = fu_done & any_issued;
   assign pop         = ~mw_we & head_done;

   longop_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock           (clock),
      .reset           (reset),
      .push            (push),
      .push_rd         (issue_rd),
      .push_op         (issue_op),
      .complete        (complete),
      .complete_result (fu_result),
      .complete_exc    (fu_exception),
      .pop             (pop),
      .head_done       (head_done),
      .head_rd         (head_rd),
      .head_op         (head_op),
      .head_result     (head_result),
      .head_exc        (head_exc),
      .occupancy       (occupancy),
      .any_issued      (any_issued)
   );

   // Write-port merge: MW wins; otherwise a DONE head retires, faults redirect to $rstatus.
   always_comb begin
      wr_en   = 1'b0;
      wr_reg  = '0;
      wr_data = '0;
      if (mw_we) begin
         wr_en   = 1'b1;
         wr_reg  = mw_rd;
         wr_data = mw_data;
      end else if (head_done) begin
         if (head_exc) begin
            wr_en   = 1'b1;
            wr_reg  = 5'(RSTATUS);
            wr_data = XLEN'(exc_code(head_op));
         end else begin
            wr_en   = (head_rd != 5'd0);
            wr_reg  = head_rd;
            wr_data = head_result;
         end
      end
   end

   // Next pending mask: retiring clears, a same-cycle issue to the same register wins.
   always_comb begin
      pending_d = pending_q;
      if (pop) begin
         pending_d[head_rd] = 1'b0;
      end
      if (push && issue_rd != 5'd0) begin
         pending_d[issue_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Starvation count of denied cycles; a raised hold always restarts the count.
   always_comb begin
      starve_d = starve_q;
      if (pop || hold_q) begin
         starve_d = '0;
      end else if (head_done && mw_we && starve_q != STV_W'(STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
      hold_d = ~hold_q & (starve_d == STV_W'(STARVE_MAX));
   end

   // Registered pending mask, starvation state, hold flag and sticky protocol error.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
         starve_q  <= '0;
         hold_q    <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         pending_q <= pending_d;
         starve_q  <= starve_d;
         hold_q    <= hold_d;
         perr_q    <= perr_q | (fu_done & ~any_issued);
      end
   end

   // Decode hazards come only from the registered mask; r0 never stalls.
   always_comb begin
      dep_stall = ((src_a != 5'd0) && pending_q[src_a])
               || ((src_b != 5'd0) && pending_q[src_b])
               || (dst_valid && (dst != 5'd0) && pending_q[dst]);
   end

   assign pending_mask = pending_q;
   assign mw_hold      = hold_q;
   assign protocol_err = perr_q;

endmodule

// File: tb/tb_longop_scoreboard.sv
// Self-checking bench for longop_scoreboard: a model FIFO predicts occupancy
// and retirement, expected long-op writes are queued when fu_done is driven
// and popped when the DUT should retire the head.
module tb_longop_scoreboard;
   import longop_scoreboard_pkg::*;

   localparam int XLEN       = 32;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;
   localparam int RSTATUS    = 30;

   logic              clock;
   logic              reset;
   logic              issue_valid;
   logic              issue_op;
   logic [4:0]        issue_rd;
   logic              issue_ready;
   logic              fu_done;
   logic [XLEN-1:0]   fu_result;
   logic              fu_exception;
   logic [4:0]        src_a;
   logic [4:0]        src_b;
   logic [4:0]        dst;
   logic              dst_valid;
   logic              dep_stall;
   logic              mw_we;
   logic [4:0]        mw_rd;
   logic [XLEN-1:0]   mw_data;
   logic              mw_hold;
   logic              wr_en;
   logic [4:0]        wr_reg;
   logic [XLEN-1:0]   wr_data;
   logic [31:0]       pending_mask;
   logic [1:0]        occupancy;
   logic              protocol_err;

   longop_scoreboard #(
      .XLEN       (XLEN),
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX),
      .RSTATUS    (RSTATUS)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .issue_op     (issue_op),
      .issue_rd     (issue_rd),
      .issue_ready  (issue_ready),
      .fu_done      (fu_done),
      .fu_result    (fu_result),
      .fu_exception (fu_exception),
      .src_a        (src_a),
      .src_b        (src_b),
      .dst          (dst),
      .dst_valid    (dst_valid),
      .dep_stall    (dep_stall),
      .mw_we        (mw_we),
      .mw_rd        (mw_rd),
      .mw_data      (mw_data),
      .mw_hold      (mw_hold),
      .wr_en        (wr_en),
      .wr_reg       (wr_reg),
      .wr_data      (wr_data),
      .pending_mask (pending_mask),
      .occupancy    (occupancy),
      .protocol_err (protocol_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [4:0] rd;
      logic       op;
      logic       done;
   } model_entry_t;

   typedef struct {
      logic        en;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_write_t;

   model_entry_t modelFifo[$];
   exp_write_t   expQueue[$];
   logic         modelPerr;
   int           testCount;
   int           failCount;

   logic         nextMwWe;
   logic [4:0]   nextMwRd;
   logic [31:0]  nextMwData;
   logic [4:0]   nextSrcA;
   logic [4:0]   nextSrcB;
   logic [4:0]   nextDst;
   logic         nextDstValid;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle, checks the write port against the scoreboard, then advances the model.
   task automatic applyStimulus(input logic iv, input logic iop, input logic [4:0] ird,
                                input logic done, input logic [31:0] res, input logic exc);
      bit           accept;
      bit           modelPop;
      bit           found;
      exp_write_t   e;
      model_entry_t m;
      @(posedge clock);
      #1;
      issue_valid  = iv;
      issue_op     = iop;
      issue_rd     = ird;
      fu_done      = done;
      fu_result    = res;
      fu_exception = exc;
      mw_we        = nextMwWe & ~mw_hold;
      mw_rd        = nextMwRd;
      mw_data      = nextMwData;
      src_a        = nextSrcA;
      src_b        = nextSrcB;
      dst          = nextDst;
      dst_valid    = nextDstValid;
      #2;
      accept   = iv && (modelFifo.size() < DEPTH);
      modelPop = (modelFifo.size() > 0) && modelFifo[0].done && !mw_we;
      checkOutput("occupancy", 32'(occupancy), 32'(modelFifo.size()));
      checkOutput("issue_ready", 32'(issue_ready), 32'(modelFifo.size() < DEPTH));
      checkOutput("protocol_err", 32'(protocol_err), 32'(modelPerr));
      if (mw_we) begin
         checkOutput("mw_pass_en", 32'(wr_en), 32'd1);
         checkOutput("mw_pass_reg", 32'(wr_reg), 32'(mw_rd));
         checkOutput("mw_pass_data", wr_data, mw_data);
      end else if (modelPop) begin
         e = expQueue.pop_front();
         checkOutput("long_wr_en", 32'(wr_en), 32'(e.en));
         if (e.en) begin
            checkOutput("long_wr_reg", 32'(wr_reg), 32'(e.rd));
            checkOutput("long_wr_data", wr_data, e.data);
         end
      end else begin
         checkOutput("idle_wr_en", 32'(wr_en), 32'd0);
      end
      if (done) begin
         found = 1'b0;
         foreach (modelFifo[i]) begin
            if (!found && !modelFifo[i].done) begin
               modelFifo[i].done = 1'b1;
               m = modelFifo[i];
               found = 1'b1;
            end
         end
         if (found) begin
            e.en   = exc || (m.rd != 5'd0);
            e.rd   = exc ? 5'(RSTATUS) : m.rd;
            e.data = exc ? (m.op ? 32'd5 : 32'd4) : res;
            expQueue.push_back(e);
         end else begin
            modelPerr = 1'b1;
         end
      end
      if (modelPop) begin
         void'(modelFifo.pop_front());
      end
      if (accept) begin
         m.rd   = ird;
         m.op   = iop;
         m.done = 1'b0;
         modelFifo.push_back(m);
      end
   endtask

   task automatic idle();
      applyStimulus(1'b0, MULT_OP, 5'd0, 1'b0, 32'd0, 1'b0);
   endtask

   // Checks every output against its reset value.
   task automatic checkResetValues(input string phase);
      checkOutput({phase, "_wr_en"}, 32'(wr_en), 32'd0);
      checkOutput({phase, "_issue_ready"}, 32'(issue_ready), 32'd1);
      checkOutput({phase, "_occupancy"}, 32'(occupancy), 32'd0);
      checkOutput({phase, "_pending"}, pending_mask, 32'd0);
      checkOutput({phase, "_mw_hold"}, 32'(mw_hold), 32'd0);
      checkOutput({phase, "_dep_stall"}, 32'(dep_stall), 32'd0);
      checkOutput({phase, "_protocol_err"}, 32'(protocol_err), 32'd0);
   endtask

   initial begin
      testCount    = 0;
      failCount    = 0;
      modelPerr    = 1'b0;
      reset        = 1'b0;
      issue_valid  = 1'b0;
      issue_op     = MULT_OP;
      issue_rd     = 5'd0;
      fu_done      = 1'b0;
      fu_result    = '0;
      fu_exception = 1'b0;
      src_a        = 5'd0;
      src_b        = 5'd0;
      dst          = 5'd0;
      dst_valid    = 1'b0;
      mw_we        = 1'b0;
      mw_rd        = 5'd0;
      mw_data      = '0;
      nextMwWe     = 1'b0;
      nextMwRd     = 5'd0;
      nextMwData   = '0;
      nextSrcA     = 5'd0;
      nextSrcB     = 5'd0;
      nextDst      = 5'd0;
      nextDstValid = 1'b0;

      repeat (2) @(posedge clock);
      #3;
      checkResetValues("reset");
      reset = 1'b1;

      // Single mult rd=5, completes six cycles after issue, writes the cycle after fu_done.
      nextSrcA = 5'd5;
      applyStimulus(1'b1, MULT_OP, 5'd5, 1'b0, 32'd0, 1'b0);
      checkOutput("t1_pend_issue_cycle", 32'(pending_mask[5]), 32'd0);
      for (int c = 1; c <= 5; c++) begin
         idle();
         checkOutput("t1_pend", 32'(pending_mask[5]), 32'd1);
         checkOutput("t1_stall", 32'(dep_stall), 32'd1);
      end
      applyStimulus(1'b0, MULT_OP, 5'd0, 1'b1, 32'd42, 1'b0);
      checkOutput("t1_stall_done_cycle", 32'(dep_stall), 32'd1);
      idle();
      checkOutput("t1_wr_reg", 32'(wr_reg), 32'd5);
      checkOutput("t1_wr_data", wr_data, 32'd42);
      checkOutput("t1_stall_wb_cycle", 32'(dep_stall), 32'd1);
      idle();
      checkOutput("t1_pend_cleared", pending_mask, 32'd0);
      checkOutput("t1_stall_cleared", 32'(dep_stall), 32'd0);
      nextSrcA = 5'd0;

      // Fill both slots, a third issue is dropped, then drain in order.
      applyStimulus(1'b1, MULT_OP, 5'd3, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b1, DIV_OP, 5'd4, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b1, MULT_OP, 5'd6, 1'b0, 32'd0, 1'b0);
      checkOutput("t2_ready_full", 32'(issue_ready), 32'd0);
      checkOutput("t2_mask_full", pending_mask, 32'h0000_0018);
      idle();
      checkOutput("t2_occ_full", 32'(occupancy), 32'd2);
      applyStimulus(1'b0, MULT_OP, 5'd0, 1'b1, 32'd33, 1'b0);
      applyStimulus(1'b0, MULT_OP, 5'd0, 1'b1, 32'd44, 1'b0);
      checkOutput("t2_first_reg", 32'(wr_reg), 32'd3);
      idle();
      checkOutput("t2_second_reg", 32'(wr_reg), 32'd4);
      idle();
      checkOutput("t2_ready_back", 32'(issue_ready), 32'd1);
      checkOutput("t2_mask_empty", pending_mask, 32'd0);

      // Faulting div then mult redirect to $rstatus with codes 5 and 4.
      applyStimulus(1'b1, DIV_OP, 5'd7, 1'b0, 32'd0, 1'b0);
      idle();
      applyStimulus(1'b0, MULT_OP, 5'd0, 1'b1, 32'hdead_beef, 1'b1);
      idle();
      checkOutput("t3_div_reg", 32'(wr_reg), 32'd30);
      checkOutput("t3_div_data", wr_data, 32'd5);
      idle();
      checkOutput("t3_div_pend", 32'(pending_mask[7]), 32'd0);
      applyStimulus(1'b1, MULT_OP, 5'd8, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, MULT_OP, 5'd0, 1'b1, 32'h0000_0001, 1'b1);
      idle();
      checkOutput("t3_mult_reg", 32'(wr_reg), 32'd30);
      checkOutput("t3_mult_data", wr_data, 32'd4);
      idle();
      checkOutput("t3_mult_pend", 32'(pending_mask[8]), 32'd0);

      // Head DONE starved by continuous MW writes until the one-cycle hold.
      applyStimulus(1'b1, MULT_OP, 5'd10, 1'b0, 32'd0, 1'b0);
      nextMwWe   = 1'b1;
      nextMwRd   = 5'd11;
      nextMwData = 32'h1111_0000;
      applyStimulus(1'b0, MULT_OP, 5'd0, 1'b1, 32'h0000_1234, 1'b0);
      for (int k = 0; k < STARVE_MAX; k++) begin
         nextMwData = 32'h1111_0001 + 32'(k);
         idle();
         checkOutput("t4_hold_low", 32'(mw_hold), 32'd0);
         checkOutput("t4_mw_data", wr_data, 32'h1111_0001 + 32'(k));
      end
      idle();
      checkOutput("t4_hold_high", 32'(mw_hold), 32'd1);
      checkOutput("t4_long_reg", 32'(wr_reg), 32'd10);
      checkOutput("t4_long_data", wr_data, 32'h0000_1234);
      nextMwRd   = 5'd12;
      nextMwData = 32'h2222_0000;
      idle();
      checkOutput("t4_hold_one_cycle", 32'(mw_hold), 32'd0);
      checkOutput("t4_mw_resume_reg", 32'(wr_reg), 32'd12);
      nextMwWe = 1'b0;
      idle();

      // Re-issue to rd=9 in the cycle the older rd=9 result retires: set wins.
      applyStimulus(1'b1, MULT_OP, 5'd9, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, MULT_OP, 5'd0, 1'b1, 32'd99, 1'b0);
      applyStimulus(1'b1, DIV_OP, 5'd9, 1'b0, 32'd0, 1'b0);
      nextDst      = 5'd9;
      nextDstValid = 1'b1;
      idle();
      checkOutput("t5_pend_kept", 32'(pending_mask[9]), 32'd1);
      checkOutput("t5_waw_stall", 32'(dep_stall), 32'd1);
      nextDstValid = 1'b0;
      idle();
      checkOutput("t5_no_dst_valid", 32'(dep_stall), 32'd0);
      applyStimulus(1'b0, MULT_OP, 5'd0, 1'b1, 32'd100, 1'b0);
      idle();
      idle();
      checkOutput("t5_pend_cleared", pending_mask, 32'd0);
      nextDst = 5'd0;

      // Spurious fu_done, then an rd=0 op that retires silently.
      applyStimulus(1'b0, MULT_OP, 5'd0, 1'b1, 32'h0000_0bad, 1'b0);
      idle();
      checkOutput("t6_perr_set", 32'(protocol_err), 32'd1);
      applyStimulus(1'b1, MULT_OP, 5'd0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, MULT_OP, 5'd0, 1'b1, 32'd77, 1'b0);
      checkOutput("t6_r0_pend", pending_mask, 32'd0);
      checkOutput("t6_r0_stall", 32'(dep_stall), 32'd0);
      idle();
      idle();
      checkOutput("t6_perr_sticky", 32'(protocol_err), 32'd1);

      // Asynchronous reset in the middle of a cycle with an op in flight.
      applyStimulus(1'b1, DIV_OP, 5'd12, 1'b0, 32'd0, 1'b0);
      nextSrcA = 5'd12;
      idle();
      checkOutput("t7_stall_before_reset", 32'(dep_stall), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkResetValues("t7_async");
      modelFifo.delete();
      expQueue.delete();
      modelPerr = 1'b0;
      @(posedge clock);
      #3;
      reset    = 1'b1;
      nextSrcA = 5'd0;
      repeat (3) idle();

      checkOutput("exp_queue_drained", 32'(expQueue.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
